// File: rtl/pipelined_mac_param.sv
// Parametrised pipelined multiplier / multiply-accumulator with valid tracking and clock enable.
// Input register, PIPE_STAGES product registers, then the accumulator/output stage.
module pipelined_mac_param #(
    parameter int unsigned A_WIDTH     = 18,
    parameter int unsigned B_WIDTH     = 18,
    parameter int unsigned PIPE_STAGES = 3,
    parameter int unsigned ACC_GUARD   = 4
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic                                   CE,
    input  logic                                   IN_VALID,
    input  logic [A_WIDTH-1:0]                     A,
    input  logic [B_WIDTH-1:0]                     B,
    input  logic                                   SIGNED_IN,
    input  logic                                   ACC_IN,
    output logic                                   OUT_VALID,
    output logic [A_WIDTH+B_WIDTH+ACC_GUARD-1:0]   RESULT,
    output logic                                   OVF
);

    localparam int unsigned P_W   = A_WIDTH + B_WIDTH;
    localparam int unsigned ACC_W = P_W + ACC_GUARD;
    localparam int unsigned LAST  = PIPE_STAGES - 1;

    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    logic               s0_sgn;
    logic               s0_acc;
    logic               s0_valid;

    logic [P_W-1:0]     a_ext;
    logic [P_W-1:0]     b_ext;
    logic [P_W-1:0]     prod_c;

    logic [P_W-1:0]     p_prod  [PIPE_STAGES];
    logic               p_sgn   [PIPE_STAGES];
    logic               p_acc   [PIPE_STAGES];
    logic               p_valid [PIPE_STAGES];

    logic [ACC_W-1:0]   ext_p;
    logic [ACC_W:0]     sum_c;
    logic               ovf_c;

    // Stage 0: operand and mode capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q      <= '0;
            b_q      <= '0;
            s0_sgn   <= 1'b0;
            s0_acc   <= 1'b0;
            s0_valid <= 1'b0;
        end else if (CE) begin
            a_q      <= A;
            b_q      <= B;
            s0_sgn   <= SIGNED_IN;
            s0_acc   <= ACC_IN;
            s0_valid <= IN_VALID;
        end
    end

    // Extending both operands to P_W makes the truncated P_W product exact in either mode
    always_comb begin
        a_ext  = s0_sgn ? P_W'($signed(a_q)) : P_W'(a_q);
        b_ext  = s0_sgn ? P_W'($signed(b_q)) : P_W'(b_q);
        prod_c = a_ext * b_ext;
    end

    // Product pipe; left for synthesis to retime
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(PIPE_STAGES); i++) begin
                p_prod[i]  <= '0;
                p_sgn[i]   <= 1'b0;
                p_acc[i]   <= 1'b0;
                p_valid[i] <= 1'b0;
            end
        end else if (CE) begin
            p_prod[0]  <= prod_c;
            p_sgn[0]   <= s0_sgn;
            p_acc[0]   <= s0_acc;
            p_valid[0] <= s0_valid;
            for (int i = 1; i < int'(PIPE_STAGES); i++) begin
                p_prod[i]  <= p_prod[i-1];
                p_sgn[i]   <= p_sgn[i-1];
                p_acc[i]   <= p_acc[i-1];
                p_valid[i] <= p_valid[i-1];
            end
        end
    end

    // Accumulator add and overflow detection; RESULT is the accumulator itself
    always_comb begin
        ext_p = p_sgn[LAST] ? ACC_W'($signed(p_prod[LAST])) : ACC_W'(p_prod[LAST]);
        sum_c = {1'b0, RESULT} + {1'b0, ext_p};
        if (p_sgn[LAST]) begin
            ovf_c = (RESULT[ACC_W-1] == ext_p[ACC_W-1]) && (sum_c[ACC_W-1] != RESULT[ACC_W-1]);
        end else begin
            ovf_c = sum_c[ACC_W];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            RESULT    <= '0;
            OVF       <= 1'b0;
        end else if (CE) begin
            OUT_VALID <= p_valid[LAST];
            if (p_valid[LAST]) begin
                if (p_acc[LAST]) begin
                    RESULT <= sum_c[ACC_W-1:0];
                    OVF    <= ovf_c;
                end else begin
                    RESULT <= ext_p;
                    OVF    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_mac_param.sv
// Self-checking bench: default 18x18 instance plus a narrow 4x4, guard-less, single-pipe instance
// sharing one stimulus stream, both compared every cycle against an arithmetic reference model.
module tb_pipelined_mac_param;

    localparam int unsigned LAT0 = 5;
    localparam int unsigned LAT1 = 3;

    typedef struct {
        logic        v;
        logic [17:0] a;
        logic [17:0] b;
        logic        sg;
        logic        ac;
    } sample_t;

    logic        CLK;
    logic        RST;
    logic        CE;
    logic        IN_VALID;
    logic [17:0] A;
    logic [17:0] B;
    logic        SIGNED_IN;
    logic        ACC_IN;
    logic        ov0;
    logic [39:0] res0;
    logic        of0;
    logic        ov1;
    logic [7:0]  res1;
    logic        of1;

    int n_checks = 0;
    int n_errors = 0;

    sample_t     q0[$];
    sample_t     q1[$];
    logic [63:0] m_acc0, m_acc1;
    logic        m_vld0, m_vld1, m_ov0, m_ov1;

    pipelined_mac_param u_dut (
        .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID),
        .A(A), .B(B), .SIGNED_IN(SIGNED_IN), .ACC_IN(ACC_IN),
        .OUT_VALID(ov0), .RESULT(res0), .OVF(of0)
    );

    pipelined_mac_param #(
        .A_WIDTH(4), .B_WIDTH(4), .PIPE_STAGES(1), .ACC_GUARD(0)
    ) u_small (
        .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID),
        .A(A[3:0]), .B(B[3:0]), .SIGNED_IN(SIGNED_IN), .ACC_IN(ACC_IN),
        .OUT_VALID(ov1), .RESULT(res1), .OVF(of1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Interpret the operands mathematically, add, then wrap and judge range.
    function automatic void out_stage(input sample_t s, input int aw, input int bw, input int accw,
                                      inout logic [63:0] acc, inout logic ov, inout logic vld);
        longint av, bv, p, prev, sum, lim;
        vld = s.v;
        if (!s.v) return;
        av = longint'(s.a) & ((longint'(1) << aw) - 1);
        bv = longint'(s.b) & ((longint'(1) << bw) - 1);
        if (s.sg && av[aw-1]) av = av - (longint'(1) << aw);
        if (s.sg && bv[bw-1]) bv = bv - (longint'(1) << bw);
        p    = av * bv;
        prev = longint'(acc);
        if (s.sg && prev[accw-1]) prev = prev - (longint'(1) << accw);
        if (!s.ac) begin
            sum = p;
            ov  = 1'b0;
        end else begin
            sum = prev + p;
            lim = longint'(1) << (accw - 1);
            ov  = s.sg ? (sum < -lim || sum >= lim) : (sum >= (longint'(1) << accw));
        end
        acc = 64'(sum & ((longint'(1) << accw) - 1));
    endfunction

    task automatic model_edge(input sample_t s, input bit ce, input bit rst);
        sample_t o;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_acc0 = '0; m_acc1 = '0;
            m_vld0 = 1'b0; m_vld1 = 1'b0; m_ov0 = 1'b0; m_ov1 = 1'b0;
        end else if (ce) begin
            q0.push_back(s);
            q1.push_back(s);
            if (q0.size() == int'(LAT0)) begin
                o = q0.pop_front();
                out_stage(o, 18, 18, 40, m_acc0, m_ov0, m_vld0);
            end
            if (q1.size() == int'(LAT1)) begin
                o = q1.pop_front();
                out_stage(o, 4, 4, 8, m_acc1, m_ov1, m_vld1);
            end
        end
    endtask

    task automatic cyc(input bit v, input logic [17:0] a, input logic [17:0] b,
                       input bit sg, input bit ac, input bit ce, input bit rst);
        sample_t s;
        IN_VALID = v; A = a; B = b; SIGNED_IN = sg; ACC_IN = ac; CE = ce; RST = rst;
        s.v = v; s.a = a; s.b = b; s.sg = sg; s.ac = ac;
        @(posedge CLK);
        model_edge(s, ce, rst);
        #1;
        check("vld0", 64'(ov0), 64'(m_vld0));
        check("res0", 64'(res0), m_acc0);
        check("ovf0", 64'(of0), 64'(m_ov0));
        check("vld1", 64'(ov1), 64'(m_vld1));
        check("res1", 64'(res1), m_acc1);
        check("ovf1", 64'(of1), 64'(m_ov1));
    endtask

    task automatic send(input logic [17:0] a, input logic [17:0] b, input bit sg, input bit ac);
        cyc(1'b1, a, b, sg, ac, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    function automatic logic [17:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return 18'h3FFFF;
            1:       return 18'h20000;
            2:       return 18'($urandom_range(0, 15));
            3:       return 18'h1FFFF;
            default: return 18'($urandom);
        endcase
    endfunction

    initial begin
        RST = 1'b1; CE = 1'b0; IN_VALID = 1'b0; A = '0; B = '0; SIGNED_IN = 1'b0; ACC_IN = 1'b0;
        m_acc0 = '0; m_acc1 = '0; m_vld0 = 1'b0; m_vld1 = 1'b0; m_ov0 = 1'b0; m_ov1 = 1'b0;

        // Reset with CE low, then reset state
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("rst_res", 64'(res0), 64'h0);
        check("rst_vld", 64'(ov0), 64'h0);

        // Unsigned max x max, five-edge latency
        send(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0);
        idle(3);
        check("max_early", 64'(ov0), 64'h0);
        idle(1);
        check("max_vld", 64'(ov0), 64'h1);
        check("max_res", 64'(res0), 64'h0F_FFF8_0001);
        check("max_ovf", 64'(of0), 64'h0);

        // Back-to-back k*(k+1)
        for (int k = 0; k < 10; k++) send(18'(k), 18'(k + 1), 1'b0, 1'b0);
        idle(4);
        check("b2b_last", 64'(res0), 64'd90);

        // Signed extremes
        send(18'h20000, 18'h20000, 1'b1, 1'b0);
        send(18'h3FFFD, 18'd5, 1'b1, 1'b0);
        idle(3);
        check("sgn_min", 64'(res0), 64'h04_0000_0000);
        idle(1);
        check("sgn_neg", 64'(res0), 64'hFF_FFFF_FFF1);

        // Accumulate, then a bubble carrying ACC_IN=1
        send(18'd100, 18'd100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send(18'd10, 18'd10, 1'b0, 1'b1);
        cyc(1'b0, 18'd10, 18'd10, 1'b0, 1'b1, 1'b1, 1'b0);
        check("acc0", 64'(res0), 64'd10000);
        idle(3);
        check("acc3", 64'(res0), 64'd10300);
        idle(2);
        check("bubble", 64'(res0), 64'd10300);

        // Narrow instance overflow: unsigned then signed
        send(18'd15, 18'd15, 1'b0, 1'b0);
        send(18'd15, 18'd15, 1'b0, 1'b1);
        idle(1);
        check("u_load", 64'(res1), 64'd225);
        idle(1);
        check("u_wrap", 64'(res1), 64'd194);
        check("u_ovf", 64'(of1), 64'h1);
        send(18'd7, 18'd7, 1'b1, 1'b0);
        send(18'd7, 18'd7, 1'b1, 1'b1);
        send(18'd7, 18'd7, 1'b1, 1'b1);
        check("s_load", 64'(res1), 64'd49);
        idle(1);
        check("s_98", 64'(res1), 64'd98);
        check("s_98_ovf", 64'(of1), 64'h0);
        idle(1);
        check("s_147_ovf", 64'(of1), 64'h1);
        idle(2);

        // CE stall mid-stream
        for (int i = 0; i < 12; i++)
            cyc(1'b1, 18'(i + 3), 18'(2 * i + 1), 1'b0, 1'(i % 2), !(i >= 5 && i <= 7), 1'b0);
        idle(6);

        // Reset with samples in flight and CE low; no residue afterwards
        for (int i = 0; i < 4; i++) send(18'd50, 18'd50, 1'b0, 1'b1);
        cyc(1'b1, 18'd9, 18'd9, 1'b0, 1'b1, 1'b0, 1'b1);
        check("mid_rst_vld", 64'(ov0), 64'h0);
        check("mid_rst_res", 64'(res0), 64'h0);
        send(18'd6, 18'd7, 1'b0, 1'b1);
        idle(4);
        check("post_rst", 64'(res0), 64'd42);

        // Randomised traffic
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 6) != 0),
                1'($urandom_range(0, 99) == 0));
        idle(6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
